// File: rtl/serv_csr_irq.sv
// Bit-serial machine-mode CSR unit with software/timer/external interrupts.
// o_q/o_csr_in are combinational per beat; CSR, trap and irq updates land at the next i_clk edge.
// No backpressure: a beat is consumed on every cycle that i_en is high.
module serv_csr_irq #(
  parameter int W              = 1,
  parameter int BW             = 5 - $clog2(W),
  parameter     RESET_STRATEGY = "MINI"
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [BW-1:0] i_beat,
  input  logic          i_trig_irq,
  input  logic          i_mtip,
  input  logic          i_msip,
  input  logic          i_meip,
  input  logic          i_trap,
  input  logic          i_mret,
  input  logic          i_e_op,
  input  logic          i_ebreak,
  input  logic          i_mem_op,
  input  logic          i_mem_cmd,
  input  logic          i_mstatus_en,
  input  logic          i_mie_en,
  input  logic          i_mip_en,
  input  logic          i_mcause_en,
  input  logic [1:0]    i_csr_source,
  input  logic          i_csr_d_sel,
  input  logic [W-1:0]  i_rf_csr_out,
  input  logic [W-1:0]  i_csr_imm,
  input  logic [W-1:0]  i_rs1,
  output logic [W-1:0]  o_csr_in,
  output logic [W-1:0]  o_q,
  output logic          o_new_irq,
  output logic [3:0]    o_irq_code
);

  localparam int LW     = $clog2(W);
  localparam bit RST_EN = (RESET_STRATEGY != "NONE");

  // Beats holding the single-bit fields (mstatus/mie/mip share positions 3/7/11).
  localparam logic [BW-1:0] B3  = BW'(3 >> LW);
  localparam logic [BW-1:0] B7  = BW'(7 >> LW);
  localparam logic [BW-1:0] B11 = BW'(11 >> LW);
  localparam logic [BW-1:0] B31 = BW'(31 >> LW);

  // Interrupt vectors are ordered {external, software, timer}.
  logic       ms_mie, ms_mpie;
  logic [2:0] mie_r;
  logic [2:0] mip_r;
  logic       mcause_int;
  logic [3:0] mcause_code;
  logic       irq_r;

  logic [31:0] mstatus_w, mie_w, mip_w, mcause_w;
  logic [4:0]  base;
  logic [W-1:0] csr_q, d;
  logic [2:0]  pend;
  logic [3:0]  pend_code, trap_code;
  logic        last_beat, trap_commit;
  logic        wr_mstatus, wr_mie, wr_mcause;

  function automatic logic [W-1:0] beat_of(input logic [31:0] v, input logic [4:0] sh);
    return W'(v >> sh);
  endfunction

  // Full 32-bit views of the owned CSRs and the current beat's slice of the selected one.
  always_comb begin
    mstatus_w        = 32'h0;
    mstatus_w[12:11] = 2'b11;
    mstatus_w[7]     = ms_mpie;
    mstatus_w[3]     = ms_mie;
    mie_w            = 32'h0;
    mie_w[3]         = mie_r[1];
    mie_w[7]         = mie_r[0];
    mie_w[11]        = mie_r[2];
    mip_w            = 32'h0;
    mip_w[3]         = mip_r[1];
    mip_w[7]         = mip_r[0];
    mip_w[11]        = mip_r[2];
    mcause_w         = 32'h0;
    mcause_w[31]     = mcause_int;
    mcause_w[3:0]    = mcause_code;
    base             = 5'(i_beat) << LW;
    csr_q            = '0;
    if (i_en) begin
      if (i_mstatus_en) csr_q = csr_q | beat_of(mstatus_w, base);
      if (i_mie_en)     csr_q = csr_q | beat_of(mie_w, base);
      if (i_mip_en)     csr_q = csr_q | beat_of(mip_w, base);
      if (i_mcause_en)  csr_q = csr_q | beat_of(mcause_w, base);
    end
    o_q = i_rf_csr_out | csr_q;
    d   = i_csr_d_sel ? i_csr_imm : i_rs1;
    case (i_csr_source)
      2'b01:   o_csr_in = d;
      2'b10:   o_csr_in = o_q | d;
      2'b11:   o_csr_in = o_q & ~d;
      default: o_csr_in = o_q;
    endcase
  end

  // Pending/priority selection and the cause code a trap would record.
  always_comb begin
    pend = mip_r & mie_r & {3{ms_mie}};
    if (pend[2])      pend_code = 4'd11;
    else if (pend[1]) pend_code = 4'd3;
    else if (pend[0]) pend_code = 4'd7;
    else              pend_code = 4'd0;
    if (o_new_irq)                  trap_code = o_irq_code;
    else if (i_e_op && !i_ebreak)   trap_code = 4'd11;
    else if (i_ebreak)              trap_code = 4'd3;
    else if (i_mem_op && i_mem_cmd) trap_code = 4'd6;
    else if (i_mem_op)              trap_code = 4'd4;
    else                            trap_code = 4'd0;
    last_beat   = &i_beat;
    trap_commit = i_trap && i_en && last_beat;
    wr_mstatus  = i_en && i_mstatus_en;
    wr_mie      = i_en && i_mie_en;
    wr_mcause   = i_en && i_mcause_en;
  end

  // State update; later statements take precedence (CSR write < mret < trig < trap < reset).
  always_ff @(posedge i_clk) begin
    mip_r <= {i_meip, i_msip, i_mtip};
    if (wr_mstatus && i_beat == B3)  ms_mie   <= o_csr_in[3 % W];
    if (wr_mstatus && i_beat == B7)  ms_mpie  <= o_csr_in[7 % W];
    if (wr_mie && i_beat == B3)      mie_r[1] <= o_csr_in[3 % W];
    if (wr_mie && i_beat == B7)      mie_r[0] <= o_csr_in[7 % W];
    if (wr_mie && i_beat == B11)     mie_r[2] <= o_csr_in[11 % W];
    if (wr_mcause && i_beat == B31)  mcause_int <= o_csr_in[31 % W];
    for (int i = 0; i < 4; i++) begin
      if (wr_mcause && i_beat == BW'(i >> LW)) mcause_code[i] <= o_csr_in[i % W];
    end
    if (i_mret) begin
      ms_mie  <= ms_mpie;
      ms_mpie <= 1'b1;
    end
    if (i_trig_irq) begin
      irq_r      <= |pend;
      o_new_irq  <= (|pend) && !irq_r;
      o_irq_code <= pend_code;
    end
    if (trap_commit) begin
      mcause_int  <= o_new_irq;
      mcause_code <= trap_code;
      ms_mpie     <= ms_mie;
      ms_mie      <= 1'b0;
      o_new_irq   <= 1'b0;
    end
    if (RST_EN && i_rst) begin
      ms_mie      <= 1'b0;
      ms_mpie     <= 1'b0;
      mie_r       <= 3'b0;
      mip_r       <= 3'b0;
      mcause_int  <= 1'b0;
      mcause_code <= 4'b0;
      irq_r       <= 1'b0;
      o_new_irq   <= 1'b0;
      o_irq_code  <= 4'b0;
    end
  end

endmodule

// File: tb/tb_serv_csr_irq.sv
module tb_serv_csr_irq;
  localparam int W  = 4;
  localparam int BW = 5 - $clog2(W);
  localparam int NB = 32 / W;

  localparam int C_NONE = 0, C_MSTATUS = 1, C_MIE = 2, C_MIP = 3, C_MCAUSE = 4;
  localparam int K_WORD = 0, K_IRQ = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_en;
  logic [BW-1:0] i_beat;
  logic          i_trig_irq, i_mtip, i_msip, i_meip, i_trap, i_mret;
  logic          i_e_op, i_ebreak, i_mem_op, i_mem_cmd;
  logic          i_mstatus_en, i_mie_en, i_mip_en, i_mcause_en;
  logic [1:0]    i_csr_source;
  logic          i_csr_d_sel;
  logic [W-1:0]  i_rf_csr_out, i_csr_imm, i_rs1;
  logic [W-1:0]  o_csr_in, o_q;
  logic          o_new_irq;
  logic [3:0]    o_irq_code;

  serv_csr_irq #(.W(W), .RESET_STRATEGY("MINI")) dut (
    .i_clk(clk), .i_rst(rst), .i_en(i_en), .i_beat(i_beat),
    .i_trig_irq(i_trig_irq), .i_mtip(i_mtip), .i_msip(i_msip), .i_meip(i_meip),
    .i_trap(i_trap), .i_mret(i_mret), .i_e_op(i_e_op), .i_ebreak(i_ebreak),
    .i_mem_op(i_mem_op), .i_mem_cmd(i_mem_cmd),
    .i_mstatus_en(i_mstatus_en), .i_mie_en(i_mie_en), .i_mip_en(i_mip_en),
    .i_mcause_en(i_mcause_en), .i_csr_source(i_csr_source), .i_csr_d_sel(i_csr_d_sel),
    .i_rf_csr_out(i_rf_csr_out), .i_csr_imm(i_csr_imm), .i_rs1(i_rs1),
    .o_csr_in(o_csr_in), .o_q(o_q), .o_new_irq(o_new_irq), .o_irq_code(o_irq_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          tag;
    logic [31:0] exp_q;
    logic [31:0] exp_in;
  } rec_t;

  rec_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   step   = 0;
  bit   mon_word = 1'b0;
  bit   mon_irq  = 1'b0;
  logic [31:0] acc_q, acc_in;

  // Reference model: architectural CSR contents as whole words.
  bit          m_mie, m_mpie;
  logic [31:0] m_mie_reg, m_mcause, m_mip_w;
  bit          m_irq_r, m_new;
  logic [3:0]  m_code;

  function automatic logic [31:0] m_read(input int csr);
    case (csr)
      C_MSTATUS: return 32'h1800 | (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
      C_MIE:     return m_mie_reg;
      C_MIP:     return m_mip_w;
      C_MCAUSE:  return m_mcause;
      default:   return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] m_pend_code(input logic [31:0] p);
    if (p[11])     return 4'd11;
    else if (p[3]) return 4'd3;
    else if (p[7]) return 4'd7;
    return 4'd0;
  endfunction

  // quals = {e_op, ebreak, mem_op, mem_cmd}
  function automatic logic [3:0] m_exc(input logic [3:0] quals);
    if (quals[3] && !quals[2]) return 4'd11;
    if (quals[2])              return 4'd3;
    if (quals[1] && quals[0])  return 4'd6;
    if (quals[1])              return 4'd4;
    return 4'd0;
  endfunction

  task automatic m_trig();
    logic [31:0] p;
    p       = m_mip_w & m_mie_reg & (m_mie ? 32'hFFFF_FFFF : 32'h0);
    m_new   = (p != 0) && !m_irq_r;
    m_irq_r = (p != 0);
    m_code  = m_pend_code(p);
  endtask

  task automatic cmp(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %08h expected %08h", nm, tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_en = 0; i_beat = '0; i_trig_irq = 0; i_trap = 0; i_mret = 0;
    i_e_op = 0; i_ebreak = 0; i_mem_op = 0; i_mem_cmd = 0;
    i_mstatus_en = 0; i_mie_en = 0; i_mip_en = 0; i_mcause_en = 0;
    i_csr_source = 2'b00; i_csr_d_sel = 0;
    i_rf_csr_out = '0; i_csr_imm = '0; i_rs1 = '0;
  endtask

  // One serial word on the CSR port, optionally with trap/trig/mret on the last beat.
  task automatic csr_word(input int csr, input logic [1:0] src, input bit dsel,
                          input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rf,
                          input bit trap, input bit trig_last, input bit mret_last,
                          input logic [3:0] quals, input bit use_exp, input logic [31:0] exp_q);
    logic [31:0] q, dv, nv;
    bit          old_new;
    logic [3:0]  old_code;
    rec_t        r;
    q  = rf | m_read(csr);
    dv = dsel ? imm : rs1;
    case (src)
      2'b01:   nv = dv;
      2'b10:   nv = q | dv;
      2'b11:   nv = q & ~dv;
      default: nv = q;
    endcase
    step++;
    r.kind = K_WORD; r.tag = step; r.exp_q = use_exp ? exp_q : q; r.exp_in = nv;
    sbq.push_back(r);
    for (int b = 0; b < NB; b++) begin
      @(posedge clk); #1;
      i_en = 1; i_beat = BW'(b);
      i_mstatus_en = (csr == C_MSTATUS); i_mie_en = (csr == C_MIE);
      i_mip_en = (csr == C_MIP); i_mcause_en = (csr == C_MCAUSE);
      i_csr_source = src; i_csr_d_sel = dsel;
      i_csr_imm = imm[b*W +: W]; i_rs1 = rs1[b*W +: W]; i_rf_csr_out = rf[b*W +: W];
      i_trap = trap;
      {i_e_op, i_ebreak, i_mem_op, i_mem_cmd} = quals;
      i_trig_irq = trig_last && (b == NB - 1);
      i_mret = mret_last && (b == NB - 1);
      mon_word = 1;
    end
    @(posedge clk); #1;
    idle_inputs();
    mon_word = 0;
    case (csr)
      C_MSTATUS: begin m_mie = nv[3]; m_mpie = nv[7]; end
      C_MIE:     m_mie_reg = nv & 32'h0000_0888;
      C_MCAUSE:  m_mcause = nv & 32'h8000_000F;
      default: ;
    endcase
    old_new  = m_new;
    old_code = m_code;
    if (trig_last) m_trig();
    if (mret_last && !trap) begin m_mie = m_mpie; m_mpie = 1; end
    if (trap) begin
      m_mcause = {old_new, 27'b0, old_new ? old_code : m_exc(quals)};
      m_mpie   = m_mie;
      m_mie    = 0;
      m_new    = 0;
    end
  endtask

  task automatic chk_irq(input bit use_exp, input logic [4:0] exp);
    rec_t r;
    step++;
    r.kind = K_IRQ; r.tag = step;
    r.exp_q = use_exp ? {27'b0, exp} : {27'b0, m_new, m_code};
    r.exp_in = '0;
    sbq.push_back(r);
    mon_irq = 1;
    @(posedge clk); #1;
    mon_irq = 0;
  endtask

  task automatic trig(input bit use_exp, input logic [4:0] exp);
    @(posedge clk); #1; i_trig_irq = 1;
    @(posedge clk); #1; i_trig_irq = 0;
    m_trig();
    chk_irq(use_exp, exp);
  endtask

  task automatic set_lines(input bit msip, input bit mtip, input bit meip);
    i_msip = msip; i_mtip = mtip; i_meip = meip;
    m_mip_w = (msip ? 32'h8 : 32'h0) | (mtip ? 32'h80 : 32'h0) | (meip ? 32'h800 : 32'h0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic mret();
    @(posedge clk); #1; i_mret = 1;
    @(posedge clk); #1; i_mret = 0;
    m_mie = m_mpie; m_mpie = 1;
  endtask

  task automatic rd(input int csr, input logic [31:0] exp);
    csr_word(csr, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0, 1, exp);
  endtask

  task automatic trap(input logic [3:0] quals);
    csr_word(C_NONE, 2'b00, 0, 0, 0, 0, 1, 0, 0, quals, 0, 0);
  endtask

  // Monitor: assembles serial words and compares them, and irq outputs when strobed.
  always @(negedge clk) begin
    rec_t r;
    if (mon_word && i_en) begin
      acc_q[int'(i_beat)*W +: W]  = o_q;
      acc_in[int'(i_beat)*W +: W] = o_csr_in;
      if (int'(i_beat) == NB - 1) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL word: no expected entry queued");
        end else begin
          r = sbq.pop_front();
          cmp("entry kind", r.tag, K_WORD, r.kind);
          cmp("o_q word", r.tag, acc_q, r.exp_q);
          cmp("o_csr_in word", r.tag, acc_in, r.exp_in);
        end
      end
    end
    if (mon_irq) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL irq: no expected entry queued");
      end else begin
        r = sbq.pop_front();
        cmp("entry kind", r.tag, K_IRQ, r.kind);
        cmp("{o_new_irq,o_irq_code}", r.tag, {27'b0, o_new_irq, o_irq_code}, r.exp_q);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    idle_inputs();
    i_mtip = 0; i_msip = 0; i_meip = 0;
    m_mie = 0; m_mpie = 0; m_mie_reg = 0; m_mcause = 0; m_mip_w = 0;
    m_irq_r = 0; m_new = 0; m_code = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Reset state
    chk_irq(1, 5'h00);
    rd(C_MSTATUS, 32'h0000_1800);
    rd(C_MCAUSE,  32'h0000_0000);

    // csrrsi mstatus,8 then csrrs mie,0x80
    csr_word(C_MSTATUS, 2'b10, 1, 32'h8, 0, 0, 0, 0, 0, 4'b0, 1, 32'h0000_1800);
    csr_word(C_MIE, 2'b10, 0, 0, 32'h80, 0, 0, 0, 0, 4'b0, 1, 32'h0);
    rd(C_MSTATUS, 32'h0000_1808);
    rd(C_MIE,     32'h0000_0080);

    // Timer interrupt, trap, then no re-request while MIE=0
    set_lines(0, 1, 0);
    rd(C_MIP, 32'h0000_0080);
    trig(1, 5'h17);
    trap(4'b0);
    rd(C_MCAUSE,  32'h8000_0007);
    rd(C_MSTATUS, 32'h0000_1880);
    chk_irq(1, 5'h07);
    trig(1, 5'h00);

    // External beats timer; re-request only after irq_r has cleared
    csr_word(C_MSTATUS, 2'b10, 1, 32'h8, 0, 0, 0, 0, 0, 4'b0, 1, 32'h0000_1880);
    csr_word(C_MIE, 2'b01, 0, 0, 32'h888, 0, 0, 0, 0, 4'b0, 1, 32'h0000_0080);
    set_lines(0, 1, 1);
    trig(1, 5'h1B);
    set_lines(0, 1, 0);
    mret();
    set_lines(0, 0, 0);
    trig(1, 5'h00);
    set_lines(0, 1, 0);
    trig(1, 5'h17);

    // Exception causes
    trap(4'b1000);
    rd(C_MCAUSE, 32'h8000_0007);
    trap(4'b1000);
    rd(C_MCAUSE, 32'h0000_000B);
    trap(4'b0011);
    rd(C_MCAUSE, 32'h0000_0006);
    trap(4'b0010);
    rd(C_MCAUSE, 32'h0000_0004);
    trap(4'b1100);
    rd(C_MCAUSE, 32'h0000_0003);

    // Trap and mret together: trap wins
    csr_word(C_MSTATUS, 2'b01, 1, 32'h88, 0, 0, 0, 0, 0, 4'b0, 1, 32'h0000_1800);
    csr_word(C_NONE, 2'b00, 0, 0, 0, 0, 1, 0, 1, 4'b0, 0, 0);
    rd(C_MSTATUS, 32'h0000_1880);

    // csrrc mcause
    csr_word(C_MCAUSE, 2'b01, 0, 0, 32'h8000_000B, 0, 0, 0, 0, 4'b0, 0, 0);
    csr_word(C_MCAUSE, 2'b11, 0, 0, 32'h8000_0001, 0, 0, 0, 0, 4'b0, 1, 32'h8000_000B);
    rd(C_MCAUSE, 32'h0000_000A);

    // Randomized mix against the reference model
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        bit tr, tg, mr;
        tr = ($urandom_range(0, 4) == 0);
        tg = ($urandom_range(0, 3) == 0);
        mr = tr && $urandom_range(0, 1);
        csr_word($urandom_range(0, 4), 2'($urandom), 1'($urandom), $urandom, $urandom,
                 ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h0,
                 tr, tg, mr, 4'($urandom), 0, 0);
      end else if (op <= 7) begin
        set_lines(1'($urandom), 1'($urandom), 1'($urandom));
        trig(0, 0);
      end else if (op == 8) begin
        mret();
      end else begin
        chk_irq(0, 0);
      end
    end

    repeat (3) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d entries left expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
